// File: rtl/rr_lease_arbiter.sv
// rr_lease_arbiter: round-robin lease arbiter for one shared resource.
// One of N requesters holds a lease until it pulses done or drops its
// request; an all-zero grant cycle always separates two leases.
// Optional hold limit: define LEASE_TIMEOUT_EN to revoke leases after
// MAX_HOLD grant cycles and mask the overrunning requester until it
// drops its request.
//
// Handshake: request[i] is a level held by requester i while it wants the
// resource; grant[i] is the registered answer. done[i] is a single-cycle
// strobe honoured only from the current holder. A lease ends at the edge
// where the holder shows done=1 or request=0; grant is low from that edge.
module rr_lease_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         request,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 timeout,
    output logic                 dbg_state_o
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    eligible;
    logic            found;
    logic [IW-1:0]   pick;
    logic            release_ev;
    logic            expire_ev;
    logic [IW-1:0]   next_ptr;

`ifdef LEASE_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    mask_q, mask_d;
    logic            timeout_q, timeout_d;

    assign eligible = request & ~mask_q;
    // Hold limit is reached only when no release is pending; a coincident
    // release wins and is handled as an ordinary end of lease.
    assign expire_ev = (state_q == GRANT) && !release_ev && (hold_cnt_q == HOLD_LIM);
    assign timeout   = timeout_q;
`else
    assign eligible  = request;
    assign expire_ev = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign release_ev  = (state_q == GRANT) && (done[grant_id_q] || !request[grant_id_q]);
    assign next_ptr    = (grant_id_q == LAST) ? '0 : grant_id_q + 1'b1;

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

    // Rotating priority search: first eligible index at or above ptr, wrapping.
    always_comb begin
        int j;
        logic [IW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j   = (int'(ptr_q) + i) % N;
            idx = IW'(j);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // State register plus registered outputs; reset drops everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
`ifdef LEASE_TIMEOUT_EN
            hold_cnt_q <= '0;
            mask_q     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
`ifdef LEASE_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // Next-state logic: IDLE grants on any eligible request, GRANT leaves on
    // release or hold-limit expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = GRANT;
            GRANT:   if (release_ev || expire_ev) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and pointer logic: values presented from the next edge on.
    always_comb begin
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
                if (found) begin
                    grant_d    = ONE << pick;
                    grant_id_d = pick;
                    busy_d     = 1'b1;
                end
            end
            GRANT: begin
                if (release_ev || expire_ev) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    busy_d     = 1'b0;
                    // Served requester drops to lowest priority next round.
                    ptr_d      = next_ptr;
                end
            end
            default: begin
                grant_d    = '0;
                grant_id_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

`ifdef LEASE_TIMEOUT_EN
    // Hold counter, timeout pulse and overrun mask bookkeeping.
    always_comb begin
        hold_cnt_d = '0;
        timeout_d  = expire_ev;
        // A masked requester is released as soon as it lowers its request.
        mask_d     = mask_q & request;
        if (state_q == IDLE) begin
            if (found) hold_cnt_d = HW'(1);
        end else if (!(release_ev || expire_ev)) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LIM) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
        if (expire_ev) mask_d = mask_d | (ONE << grant_id_q);
    end
`endif

endmodule

// File: tb/tb_rr_lease_arbiter.sv
// Directed bench for rr_lease_arbiter (N=3, MAX_HOLD=8).
module tb_rr_lease_arbiter;

    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic [N-1:0] request;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;
    logic         dbg_state;

    int n_cmp;
    int n_bad;

    rr_lease_arbiter #(.N(N), .MAX_HOLD(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout     (timeout),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] eg, input logic [1:0] eid,
                           input logic eb, input logic et);
        chk({tag, ".grant"},    32'(grant),    32'(eg));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(eid));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".timeout"},  32'(timeout),  32'(et));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("rst", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [2:0] exp_g  [10];
    logic [1:0] exp_id [10];

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        request = '0;
        done    = '0;

        // 1: reset state and idle with no requests
        #3;
        chk_all("t1_reset", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("t1_idle", 3'b000, 2'd0, 1'b0, 1'b0);
        end

        // 2: single requester, foreign done ignored, own done releases
        request = 3'b001;
        tick();
        chk_all("t2_grant", 3'b001, 2'd0, 1'b1, 1'b0);
        done = 3'b010;
        tick();
        chk_all("t2_foreign_done", 3'b001, 2'd0, 1'b1, 1'b0);
        done = 3'b000;
        tick();
        chk_all("t2_hold", 3'b001, 2'd0, 1'b1, 1'b0);
        done    = 3'b001;
        request = 3'b000;
        tick();
        chk_all("t2_release", 3'b000, 2'd0, 1'b0, 1'b0);
        done = 3'b000;
        tick();
        chk_all("t2_idle", 3'b000, 2'd0, 1'b0, 1'b0);

        // 3: round robin with all three requesting
        do_reset();
        exp_g  = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
        request = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_grant",    32'(grant),    32'(exp_g[i]));
            chk("t3_grant_id", 32'(grant_id), 32'(exp_id[i]));
            chk("t3_busy",     32'(busy),     32'(exp_g[i] != 3'b000));
            case (i)
                1:       done = 3'b001;
                4:       done = 3'b010;
                7:       done = 3'b100;
                default: done = 3'b000;
            endcase
        end
        done = 3'b000;

        // 4: hold limit
        do_reset();
        request = 3'b010;
`ifdef LEASE_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("t4_held", 3'b010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        chk_all("t4_timeout", 3'b000, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("t4_masked", 3'b000, 2'd0, 1'b0, 1'b0);
        end
        request = 3'b000;
        tick();
        chk_all("t4_drop", 3'b000, 2'd0, 1'b0, 1'b0);
        request = 3'b010;
        tick();
        chk_all("t4_regrant", 3'b010, 2'd1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 55; i++) begin
            tick();
            chk_all("t4_no_limit", 3'b010, 2'd1, 1'b1, 1'b0);
        end
`endif

        // 5: asynchronous reset mid-lease, pointer returns to 0
        do_reset();
        request = 3'b100;
        tick();
        chk_all("t5_grant2", 3'b100, 2'd2, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("t5_async", 3'b000, 2'd0, 1'b0, 1'b0);
        request = 3'b111;
        tick();
        chk_all("t5_in_reset", 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk_all("t5_first", 3'b001, 2'd0, 1'b1, 1'b0);

        // 6: release coinciding with the hold-limit edge
        do_reset();
        request = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("t6_held", 3'b001, 2'd0, 1'b1, 1'b0);
        end
        done = 3'b001;
        tick();
        chk_all("t6_release", 3'b000, 2'd0, 1'b0, 1'b0);
        done = 3'b000;
        tick();
        chk_all("t6_regrant", 3'b001, 2'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_lease_arbiter.md
Name: rr_lease_arbiter

Overview:
- Round-robin arbiter that leases one shared resource to one of N requesters at a time.
- A lease is held until the holder signals done, drops its request, or (optionally) overruns a hold limit.
- Sits between the requesting engines and the shared datapath; its registered one-hot grant drives the resource's select mux.

Parameters:
- N, 3, number of requesters (legal 2..8).
- MAX_HOLD, 8, maximum consecutive grant cycles per lease when the timeout feature is compiled in (legal >= 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- request  input  N  request[i]=1: requester i wants the resource
- done  input  N  done[i]=1 for one cycle: holder i ends its lease; ignored for non-holders
- grant  output  N  registered one-hot grant, or all-zero
- grant_id  output  $clog2(N)  index of the current holder; 0 when grant=0
- busy  output  1  1 while in GRANT state
- timeout  output  1  one-cycle pulse when a lease is revoked by the hold limit

Behaviour:
- Reset (reset=0, asynchronous): grant=0, grant_id=0, busy=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0, mask=0. All outputs drop immediately, including mid-lease.
- State register: IDLE and GRANT. All outputs are registered.
- IDLE:
  - Arbitrate over eligible = request & ~mask, searching from index ptr upward with wrap-around.
  - If any requester is eligible at edge k, the first match g is granted: grant=1<<g, grant_id=g, busy=1 from edge k onward; hold_cnt=1; state goes to GRANT.
  - If none is eligible, remain in IDLE with grant=0.
- GRANT (holder g):
  - Release condition: done[g]=1 or request[g]=0, sampled at the edge.
  - On release: grant=0, busy=0, state goes to IDLE, ptr=(g+1) mod N.
  - Otherwise hold, and hold_cnt increments (saturating).
  - This guarantees at least one all-zero grant cycle between leases, which is the bus turnaround.
- done bits for non-holders are ignored in every state. Request changes in GRANT affect only the next arbitration.
- Fairness: after requester g is served, it has the lowest priority at the next arbitration.
- Width rules:
  - hold_cnt is $clog2(MAX_HOLD+1) bits.
  - ptr and grant_id are $clog2(N) bits.
  - Pointer wrap: (N-1)+1 gives 0.
- Simultaneous events:
  - Release and hold-limit expiry at the same edge: treated as a normal release, with timeout=0 and no mask.
  - A request from g that rises in the same cycle as g's release does not extend g's lease.

Optional Feature:
- Macro: LEASE_TIMEOUT_EN
- Defined:
  - At the edge that ends the MAX_HOLD-th grant cycle, if no release is pending: grant=0, busy=0, timeout=1 for exactly one cycle, ptr=(g+1) mod N, mask[g]=1, state goes to IDLE.
  - mask[g] clears at the first edge where request[g]=0. While masked, g is never granted.
- Undefined:
  - No hold limit: hold_cnt, mask and the timeout logic are removed.
  - timeout is tied to 0, and leases last until release.

Test Plan:
1. Reset, then request=3'b000 for 10 cycles -> grant=000, busy=0, timeout=0 throughout.
2. request=3'b001 sampled at edge k -> grant=001, grant_id=0, busy=1 from edge k. Pulse done[0] at edge k+3 -> grant=000 from edge k+3. A done[1] pulse during the lease has no effect.
3. request=3'b111 held; each holder pulses done in its second grant cycle -> grant sequence 001,001,000,010,010,000,100,100,000,001; grant_id sequence 0,0,0,1,1,0,2,2,0,0.
4. LEASE_TIMEOUT_EN, MAX_HOLD=8, request=3'b010 held, no done:
   - grant=010 for exactly 8 cycles, then grant=000 with timeout=1 for one cycle.
   - No regrant while request[1] stays high.
   - Drop request[1] for one cycle and raise it again -> regranted.
   - With the macro undefined: grant=010 held for 50+ cycles and timeout stays 0.
5. reset driven low mid-lease (grant=100) -> grant=000 and busy=0 immediately. After release of reset with request=3'b111 -> first grant=001 (ptr back to 0).
6. LEASE_TIMEOUT_EN: done[0] asserted at the edge ending cycle 8 of requester 0's lease -> grant=000, timeout=0, mask clear. A later request[0] is granted normally.
